// File: rtl/bash_f_ctrl.sv
// bash_f_ctrl: iterative bash-f permutation built around a single bash_f_stage.
// A state is taken over valid/ready, re-circulated through the stage for ROUNDS
// cycles, then captured into a held output register with its own valid/ready.
// Build macro BASH_F_CONST_ROM_EN: round constants come from a precomputed table
// indexed by the round counter instead of the shift/XOR constant register.

module bash_f_ctrl #(
  parameter int unsigned ROUNDS = 24,
  parameter logic [63:0] C_INIT = 64'h3BF5080AC8BA94B1,
  parameter logic [63:0] C_POLY = 64'hDC2BE1997FE0D8AE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [1535:0] data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [1535:0] data_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] LAST_RND = 5'(ROUNDS);

  state_t        state_q, state_d;
  logic [4:0]    rnd_q, rnd_d;
  logic          valid_q, valid_d;
  logic [1535:0] data_q, data_d;
  logic [1535:0] stage_in, stage_out;
  logic [63:0]   c_cur;
  logic          accept;

  function automatic logic [63:0] c_step(input logic [63:0] c);
    return (c >> 1) ^ (c[0] ? C_POLY : 64'd0);
  endfunction

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q == RUN);
  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign accept   = valid_i & ready_o;
  assign stage_in = accept ? data_i : stage_out;

  bash_f_stage u_stage (
    .clk    (clk),
    .c_i    (c_cur),
    .data_i (stage_in),
    .data_o (stage_out)
  );

`ifdef BASH_F_CONST_ROM_EN
  // Table entry k holds the constant for round k+1; ROUNDS must not exceed 24.
  function automatic logic [1535:0] build_c_rom();
    logic [1535:0] rom;
    logic [63:0]   c;
    rom = '0;
    c   = C_INIT;
    for (int i = 0; i < 24; i++) begin
      rom[i*64 +: 64] = c;
      c = c_step(c);
    end
    return rom;
  endfunction

  localparam logic [1535:0] C_ROM = build_c_rom();

  // Look up the constant for the round the stage is about to compute.
  always_comb begin
    c_cur = C_INIT;
    if (rnd_q < 5'd24) c_cur = C_ROM[{rnd_q, 6'd0} +: 64];
  end
`else
  logic [63:0] c_q, c_d;

  assign c_cur = c_q;

  // Advance the round constant alongside the round counter; rewind to C_INIT when idle.
  always_comb begin
    c_d = c_q;
    unique case (state_q)
      IDLE:    c_d = accept ? c_step(C_INIT) : C_INIT;
      RUN:     c_d = (rnd_q == LAST_RND) ? C_INIT : c_step(c_q);
      default: c_d = C_INIT;
    endcase
  end

  // Constant register, reset to the first-round constant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) c_q <= C_INIT;
    else        c_q <= c_d;
  end
`endif

  // Next-state logic: accept in IDLE, count rounds in RUN, hold the result in DONE.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    valid_d = valid_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        rnd_d = 5'd0;
        if (accept) begin
          state_d = RUN;
          rnd_d   = 5'd1;
        end
      end
      RUN: begin
        if (rnd_q == LAST_RND) begin
          data_d  = stage_out;
          valid_d = 1'b1;
          state_d = DONE;
          rnd_d   = 5'd0;
        end else begin
          rnd_d = rnd_q + 5'd1;
        end
      end
      DONE: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset discards any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= 5'd0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// bash_f_stage: one bash-f round (eight bash-s columns, word shuffle, constant
// injection into S[23]) followed by an unreset output register.
module bash_f_stage (
  input  logic          clk,
  input  logic [63:0]   c_i,
  input  logic [1535:0] data_i,
  output logic [1535:0] data_o
);

  localparam int M1 [8] = '{8, 56, 8, 56, 8, 56, 8, 56};
  localparam int N1 [8] = '{53, 51, 37, 3, 21, 19, 5, 35};
  localparam int M2 [8] = '{14, 34, 46, 2, 14, 34, 46, 2};
  localparam int N2 [8] = '{1, 7, 49, 23, 33, 39, 17, 55};
  localparam int PERM [24] = '{15, 10, 9, 12, 11, 14, 13, 8,
                               17, 16, 19, 18, 21, 20, 23, 22,
                               6, 3, 0, 5, 2, 7, 4, 1};

  logic [63:0]   s_in  [24];
  logic [63:0]   s_mix [24];
  logic [1535:0] data_d, data_q;

  function automatic logic [63:0] rot_hi(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  function automatic logic [191:0] bash_s(input logic [63:0] a0, a1, a2,
                                          input int m1, n1, m2, n2);
    logic [63:0] w0, w1, w2, t0, t1, t2;
    t0 = rot_hi(a0, m1);
    w0 = a0 ^ a1 ^ a2;
    t1 = a1 ^ rot_hi(w0, n1);
    w1 = t0 ^ t1;
    w2 = a2 ^ rot_hi(a2, m2) ^ rot_hi(t1, n2);
    t0 = ~w2 | w1;
    t1 = w0 | w2;
    t2 = w0 & w1;
    return {w0 ^ t0, w1 ^ t1, w2 ^ t2};
  endfunction

  for (genvar i = 0; i < 24; i++) begin : g_unpack
    assign s_in[i] = data_i[1535 - 64*i -: 64];
  end

  for (genvar j = 0; j < 8; j++) begin : g_col
    assign {s_mix[j], s_mix[j+8], s_mix[j+16]} =
      bash_s(s_in[j], s_in[j+8], s_in[j+16], M1[j], N1[j], M2[j], N2[j]);
  end

  for (genvar i = 0; i < 24; i++) begin : g_pack
    if (i == 23) begin : g_last
      assign data_d[1535 - 64*i -: 64] = s_mix[PERM[i]] ^ c_i;
    end else begin : g_word
      assign data_d[1535 - 64*i -: 64] = s_mix[PERM[i]];
    end
  end

  // Round result register; free-running, no enable and no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data_o = data_q;

endmodule
